// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - data memory port arbiter between CPU pipeline and DMA requester
//
// Purpose: shares the single-port DM between the EX_DM stage and a DMA loader. The CPU has
// priority, the DMA is forced ahead after MAX_STARVE denied cycles and may hold locked bursts
// of up to BURST_MAX beats. The CPU is stalled whenever it has an access but loses the port.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cpu_re/we/addr/wdata            CPU access from EX_DM
//   cpu_stall, cpu_rdata            CPU freeze, load data (cycle after grant)
//   dma_req/we/last/addr/wdata      DMA beat request, held until dma_gnt
//   dma_gnt, dma_rvalid, dma_rdata  beat accept, registered read return
//   mem_re/we/addr/wdata, mem_rdata DM port (1-cycle synchronous read)
//   perf_clr, cpu_stall_cnt,
//   dma_force_cnt                   only with DM_ARB_PERF_EN defined
//
// Configuration macro: DM_ARB_PERF_EN adds saturating stall / forced-grant counters.

module dm_port_arbiter #(
  parameter int AW         = 16,
  parameter int MAX_STARVE = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_re,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_wdata,
  output logic          cpu_stall,
  output logic [15:0]   cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic          dma_last,
  input  logic [AW-1:0] dma_addr,
  input  logic [15:0]   dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [15:0]   dma_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata
`ifdef DM_ARB_PERF_EN
  ,
  input  logic          perf_clr,
  output logic [31:0]   cpu_stall_cnt,
  output logic [15:0]   dma_force_cnt
`endif
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(MAX_STARVE);
  localparam logic [BW-1:0] BEAT_LIM   = BW'(BURST_MAX);
  localparam bit CAN_BURST = (BURST_MAX > 1);

  typedef enum logic {ARB, BURST} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] beat_cnt;
  logic          cpu_first;

  logic          cpu_act, cpu_sel, dma_sel, cpu_gnt, force_dma;
  logic          starved, cap_exit;
  logic [BW-1:0] beat_nxt;

  assign cpu_act  = cpu_re | cpu_we;
  assign starved  = (starve_cnt == STARVE_LIM);
  assign beat_nxt = beat_cnt + BW'(1);
  // Burst ended by the beat cap rather than by the DMA itself: CPU goes first next cycle.
  assign cap_exit = (state == BURST) && dma_gnt && (beat_nxt == BEAT_LIM);

  // Grants are suppressed while reset is held so the DM port is idle during reset.
  always_comb begin
    cpu_sel   = 1'b0;
    dma_sel   = 1'b0;
    force_dma = 1'b0;
    if (rst_n) begin
      if (state == BURST) begin
        dma_sel = 1'b1;
        cpu_sel = ~dma_req;
      end else if (cpu_first && cpu_act) begin
        cpu_sel = 1'b1;
      end else if (starved && dma_req) begin
        dma_sel   = 1'b1;
        force_dma = 1'b1;
      end else if (cpu_act) begin
        cpu_sel = 1'b1;
      end else begin
        dma_sel = 1'b1;
      end
    end
  end

  assign cpu_gnt   = cpu_sel & cpu_act;
  assign dma_gnt   = dma_sel & dma_req;
  assign cpu_stall = cpu_act & ~cpu_gnt;

  assign mem_re    = cpu_gnt ? cpu_re    : (dma_gnt ? ~dma_we   : 1'b0);
  assign mem_we    = cpu_gnt ? cpu_we    : (dma_gnt ? dma_we    : 1'b0);
  assign mem_addr  = cpu_gnt ? cpu_addr  : (dma_gnt ? dma_addr  : '0);
  assign mem_wdata = cpu_gnt ? cpu_wdata : (dma_gnt ? dma_wdata : '0);

  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      starve_cnt <= '0;
      beat_cnt   <= '0;
      cpu_first  <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      dma_rvalid <= dma_gnt & ~dma_we;

      if (!dma_req || dma_gnt)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + SW'(1);

      if (cap_exit)
        cpu_first <= 1'b1;
      else if (cpu_gnt || !cpu_act)
        cpu_first <= 1'b0;

      case (state)
        ARB: begin
          if (dma_gnt && !dma_last && CAN_BURST) begin
            state    <= BURST;
            beat_cnt <= BW'(1);
          end
        end
        BURST: begin
          if (!dma_req || dma_last || beat_nxt == BEAT_LIM) begin
            state    <= ARB;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_nxt;
          end
        end
        default: begin
          state    <= ARB;
          beat_cnt <= '0;
        end
      endcase
    end
  end

`ifdef DM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_stall_cnt <= '0;
      dma_force_cnt <= '0;
    end else if (perf_clr) begin
      cpu_stall_cnt <= '0;
      dma_force_cnt <= '0;
    end else begin
      if (cpu_stall && cpu_stall_cnt != '1)
        cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
      if (force_dma && dma_force_cnt != '1)
        dma_force_cnt <= dma_force_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - scoreboard testbench for dm_port_arbiter

module tb_dm_port_arbiter;

  localparam int AW         = 16;
  localparam int MAX_STARVE = 8;
  localparam int BURST_MAX  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          cpu_re = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [15:0]   cpu_wdata = '0;
  logic          cpu_stall;
  logic [15:0]   cpu_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [15:0]   dma_wdata = '0;
  logic          dma_gnt, dma_rvalid;
  logic [15:0]   dma_rdata;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata = '0;
`ifdef DM_ARB_PERF_EN
  logic          perf_clr = 1'b0;
  logic [31:0]   cpu_stall_cnt;
  logic [15:0]   dma_force_cnt;
`endif

  dm_port_arbiter #(.AW(AW), .MAX_STARVE(MAX_STARVE), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DM_ARB_PERF_EN
    , .perf_clr(perf_clr), .cpu_stall_cnt(cpu_stall_cnt), .dma_force_cnt(dma_force_cnt)
`endif
  );

  // Data memory seen by the DUT, and the bench's own reference copy.
  logic [15:0] dm     [0:65535];
  logic [15:0] ref_dm [0:65535];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= dm[mem_addr];
    if (mem_we) dm[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic          re, we;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic          stall, gnt, rvalid;
    bit            chk_d, chk_c;
    logic [15:0]   d;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  // Monitor: pops one expectation per cycle and compares the DUT away from the clock edge.
  exp_t m_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      chk("mem_re",     32'(mem_re),     32'(m_e.re));
      chk("mem_we",     32'(mem_we),     32'(m_e.we));
      chk("mem_addr",   32'(mem_addr),   32'(m_e.addr));
      chk("mem_wdata",  32'(mem_wdata),  32'(m_e.wdata));
      chk("cpu_stall",  32'(cpu_stall),  32'(m_e.stall));
      chk("dma_gnt",    32'(dma_gnt),    32'(m_e.gnt));
      chk("dma_rvalid", 32'(dma_rvalid), 32'(m_e.rvalid));
      if (m_e.chk_d) chk("dma_rdata", 32'(dma_rdata), 32'(m_e.d));
      if (m_e.chk_c) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_e.d));
    end
  end

  // Reference model: grant rules, denied-cycle count, burst beat count.
  bit  m_burst = 0, m_prio = 0;
  int  m_beats = 0, m_denied = 0;
  bit  p_dma_rd = 0, p_cpu_rd = 0;
  logic [15:0] p_data = '0;
  bit  g_cpu, g_dma, g_force;
  logic d_gnt, d_stall;
`ifdef DM_ARB_PERF_EN
  logic [31:0] m_stall_cnt = '0;
  logic [15:0] m_force_cnt = '0;
`endif

  task automatic step();
    exp_t e;
    bit act, cap;
    act = cpu_re | cpu_we;
    g_cpu = 0; g_dma = 0; g_force = 0;
    if (rst_n) begin
      if (m_burst) begin
        g_dma = dma_req;
        g_cpu = act && !dma_req;
      end else if (m_prio && act)                   g_cpu = 1;
      else if (m_denied == MAX_STARVE && dma_req) begin g_dma = 1; g_force = 1; end
      else if (act)                                 g_cpu = 1;
      else if (dma_req)                             g_dma = 1;
    end
    e.re     = g_cpu ? cpu_re    : (g_dma ? !dma_we   : 1'b0);
    e.we     = g_cpu ? cpu_we    : (g_dma ? dma_we    : 1'b0);
    e.addr   = g_cpu ? cpu_addr  : (g_dma ? dma_addr  : '0);
    e.wdata  = g_cpu ? cpu_wdata : (g_dma ? dma_wdata : '0);
    e.stall  = act && !g_cpu;
    e.gnt    = g_dma;
    e.rvalid = rst_n && p_dma_rd;
    e.chk_d  = rst_n && p_dma_rd;
    e.chk_c  = rst_n && p_cpu_rd;
    e.d      = p_data;
    exp_q.push_back(e);

    p_dma_rd = g_dma && !dma_we;
    p_cpu_rd = g_cpu && cpu_re;
    if (g_cpu) begin
      if (cpu_re) p_data = ref_dm[cpu_addr];
      if (cpu_we) ref_dm[cpu_addr] = cpu_wdata;
    end
    if (g_dma) begin
      if (!dma_we) p_data = ref_dm[dma_addr];
      else         ref_dm[dma_addr] = dma_wdata;
    end
`ifdef DM_ARB_PERF_EN
    if (!rst_n || perf_clr) begin
      m_stall_cnt = '0; m_force_cnt = '0;
    end else begin
      if (e.stall) m_stall_cnt = m_stall_cnt + 32'd1;
      if (g_force) m_force_cnt = m_force_cnt + 16'd1;
    end
`endif

    @(negedge clk);
    d_gnt   = dma_gnt;
    d_stall = cpu_stall;
    @(posedge clk);
    #1;

    if (!rst_n) begin
      m_burst = 0; m_prio = 0; m_beats = 0; m_denied = 0;
    end else begin
      cap = 0;
      if (m_burst) begin
        if (g_dma) begin
          m_beats++;
          if (m_beats == BURST_MAX) cap = 1;
          if (dma_last || m_beats == BURST_MAX) m_burst = 0;
        end else m_burst = 0;
      end else if (g_dma && !dma_last && BURST_MAX > 1) begin
        m_burst = 1;
        m_beats = 1;
      end
      m_prio   = cap;
      m_denied = (dma_req && !g_dma) ? ((m_denied < MAX_STARVE) ? m_denied + 1 : MAX_STARVE) : 0;
    end
  endtask

  // DMA stimulus: bursts of dma_left beats, request held until the model grants it.
  int dma_left = 0;

  task automatic new_beat();
    dma_req   = 1'b1;
    dma_addr  = AW'($urandom_range(0, 31));
    dma_wdata = 16'($urandom);
    dma_last  = (dma_left == 1);
  endtask

  task automatic dma_drive(input bit rnd);
    if (dma_req && !g_dma) return;
    if (dma_req && g_dma) dma_left--;
    if (dma_left <= 0) begin
      dma_left = 0;
      if (rnd && $urandom_range(0, 3) == 0) begin
        dma_left = $urandom_range(1, 6);
        dma_we   = 1'($urandom_range(0, 1));
        new_beat();
      end else dma_req = 1'b0;
    end else if (rnd && $urandom_range(0, 4) == 0) dma_req = 1'b0;
    else new_beat();
  endtask

  task automatic cpu_idle();
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  int cnt, run, max_run;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dm[i]     = 16'(i * 40503 + 4660);
      ref_dm[i] = 16'(i * 40503 + 4660);
    end
    dm[16]     = 16'hBEEF;
    ref_dm[16] = 16'hBEEF;

    // Reset state
    step(); step();
    rst_n = 1'b1;
    step();

    // CPU-only load from 0x0010, data returned next cycle
    cpu_re = 1'b1; cpu_addr = 16'h0010;
    step();
    cpu_idle();
    step();

    // Starvation: CPU stores every cycle, DMA single write beat held
`ifdef DM_ARB_PERF_EN
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
`endif
    cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    dma_left = 1; dma_we = 1'b1; new_beat();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (d_gnt) begin
        chk("starve_force_stall", 32'(d_stall), 32'd1);
        break;
      end
      if (!d_stall) cnt++;
      cpu_wdata = cpu_wdata + 16'd1;
    end
    chk("starve_cpu_grants", 32'(cnt), 32'(MAX_STARVE));
    dma_drive(0);
    cpu_idle();
`ifdef DM_ARB_PERF_EN
    @(negedge clk);
    chk("cpu_stall_cnt", cpu_stall_cnt, 32'd1);
    chk("dma_force_cnt", 32'(dma_force_cnt), 32'd1);
    chk("cpu_stall_cnt_model", cpu_stall_cnt, m_stall_cnt);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    @(negedge clk);
    chk("cpu_stall_cnt_clr", cpu_stall_cnt, 32'd0);
    chk("dma_force_cnt_clr", 32'(dma_force_cnt), 32'd0);
`endif
    step();

    // Burst cap: 6-beat DMA read against a pending CPU load
    cpu_re = 1'b1; cpu_addr = 16'h0003;
    dma_left = 6; dma_we = 1'b0; new_beat();
    run = 0; max_run = 0;
    for (int i = 0; i < 100 && (dma_left > 0); i++) begin
      step();
      run = d_gnt ? run + 1 : 0;
      if (run > max_run) max_run = run;
      dma_drive(0);
    end
    chk("burst_cap_run", 32'(max_run), 32'(BURST_MAX));
    chk("burst_all_beats", 32'(dma_left), 32'd0);
    cpu_idle();
    step();

    // Early dma_last on beat 2, CPU arrives during beat 2
    dma_left = 2; dma_we = 1'b1; new_beat();
    step(); dma_drive(0);
    cpu_re = 1'b1; cpu_addr = 16'h0010;
    step(); dma_drive(0);
    step();
    cpu_idle();
    step(); step();

    // Reset asserted mid-burst after beat 2 of a read burst
    dma_left = 4; dma_we = 1'b0; new_beat();
    step(); dma_drive(0);
    step(); dma_drive(0);
    rst_n = 1'b0; dma_req = 1'b0; dma_left = 0; cpu_idle();
    step(); step();
    rst_n = 1'b1;
    dma_left = 2; dma_we = 1'b0; new_beat();
    cpu_re = 1'b1; cpu_addr = 16'h0005;
    step(); dma_drive(0); cpu_idle();
    for (int i = 0; i < 8; i++) begin step(); dma_drive(0); end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!(cpu_re | cpu_we) || g_cpu || $urandom_range(0, 7) == 0) begin
        cnt = $urandom_range(0, 9);
        cpu_re    = (cnt >= 3 && cnt < 7);
        cpu_we    = (cnt >= 7);
        cpu_addr  = AW'($urandom_range(0, 31));
        cpu_wdata = 16'($urandom);
      end
      step();
      dma_drive(1);
    end
    cpu_idle(); dma_req = 1'b0; dma_left = 0;
    step(); step();

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
